// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: 160x120 framebuffer with a pixel-plot write port, an
// automatic clear engine and a raster scanner that emits a timed pixel stream.
// Optional macro FRAME_SCANNER_ERRCNT_EN enables the out-of-range write counter.
module vga_frame_scanner #(
    parameter int unsigned WIDTH   = 160,
    parameter int unsigned HEIGHT  = 120,
    parameter int unsigned H_BLANK = 40,
    parameter int unsigned V_BLANK = 5,
    parameter int unsigned COLOR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         iX,
    input  logic [6:0]         iY,
    input  logic [COLOR_W-1:0] iColour,
    input  logic               iPlot,
    input  logic               iClear,
    output logic               oBusy,
    output logic [7:0]         oScanX,
    output logic [6:0]         oScanY,
    output logic [COLOR_W-1:0] oColour,
    output logic               oValid,
    output logic               oHSync,
    output logic               oVSync,
    output logic               oFrameStart,
    output logic [7:0]         oErrCount
);

    localparam int unsigned H_TOTAL = WIDTH + H_BLANK;
    localparam int unsigned V_TOTAL = HEIGHT + V_BLANK;
    localparam int unsigned DEPTH   = WIDTH * HEIGHT;
    localparam int unsigned AW      = 15;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT    = HW'(WIDTH);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(HEIGHT);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [7:0]    X_LIM    = 8'(WIDTH);
    localparam logic [6:0]    Y_LIM    = 7'(HEIGHT);
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

    typedef enum logic {StIdle, StClear} clr_state_e;

    clr_state_e      state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic            busy;

    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic            scan_active;
    logic [AW-1:0]   scan_addr;

    logic            plot_in_range;
    logic [AW-1:0]   plot_addr;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [COLOR_W-1:0] wdata;

    logic [COLOR_W-1:0] mem [DEPTH];
    logic [COLOR_W-1:0] rdata;

    logic            s1_valid, s1_hs, s1_vs, s1_fs;
    logic [7:0]      s1_x;
    logic [6:0]      s1_y;

    assign busy  = (state_q == StClear);
    assign oBusy = busy;

    // Clear FSM state register; reset always (re)starts a clear from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Clear FSM next state: sweep every address once, iClear restarts the sweep.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        unique case (state_q)
            StIdle: begin
                if (iClear) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end
            end
            StClear: begin
                if (iClear) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == CLR_LAST) begin
                    state_d    = StIdle;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                clr_addr_d = '0;
            end
        endcase
    end

    // Raster counters, free running including blanking and during clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Address decode for scan read and plot/clear write; clearing owns the write port.
    always_comb begin
        scan_active   = (hcnt < H_ACT) && (vcnt < V_ACT);
        scan_addr     = scan_active ? (AW'(vcnt) * AW'(WIDTH) + AW'(hcnt)) : '0;
        plot_in_range = (iX < X_LIM) && (iY < Y_LIM);
        plot_addr     = AW'(iY) * AW'(WIDTH) + AW'(iX);
        we            = busy | (iPlot & plot_in_range);
        waddr         = busy ? clr_addr_q : plot_addr;
        wdata         = busy ? '0 : iColour;
    end

    // Framebuffer RAM, read-before-write on address collision, contents not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[scan_addr];
    end

    // Stage 1: timing markers aligned with the RAM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_fs    <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else begin
            s1_valid <= scan_active;
            s1_hs    <= (hcnt >= H_ACT);
            s1_vs    <= (vcnt >= V_ACT);
            s1_fs    <= (hcnt == '0) && (vcnt == '0);
            s1_x     <= scan_active ? 8'(hcnt) : '0;
            s1_y     <= scan_active ? 7'(vcnt) : '0;
        end
    end

    // Stage 2: registered outputs, colour forced to 0 outside the active region.
    always_ff @(posedge clk) begin
        if (reset) begin
            oValid      <= 1'b0;
            oHSync      <= 1'b0;
            oVSync      <= 1'b0;
            oFrameStart <= 1'b0;
            oScanX      <= '0;
            oScanY      <= '0;
            oColour     <= '0;
        end else begin
            oValid      <= s1_valid;
            oHSync      <= s1_hs;
            oVSync      <= s1_vs;
            oFrameStart <= s1_fs;
            oScanX      <= s1_x;
            oScanY      <= s1_y;
            oColour     <= s1_valid ? rdata : '0;
        end
    end

`ifdef FRAME_SCANNER_ERRCNT_EN
    logic [7:0] err_q;

    // Saturating count of accepted-but-out-of-range plots; iClear zeroes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else if (iClear) begin
            err_q <= '0;
        end else if (iPlot && !busy && !plot_in_range && (err_q != 8'hFF)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign oErrCount = err_q;
`else
    assign oErrCount = '0;
`endif

endmodule

// File: doc/vga_frame_scanner.md
Name: vga_frame_scanner

Overview:
- Receiving end of the pixel-plot interface: accepts (x, y, colour, plot) pixel writes from the drawing logic into a 160x120, 3-bit framebuffer.
- Continuously raster-scans the framebuffer and emits a timed pixel stream with sync and frame markers for the display side.
- Sits between the drawing module and the board VGA output, replacing the simulator adapter for hardware builds.

Parameters:
- WIDTH, 160, active pixels per line
- HEIGHT, 120, active lines per frame
- H_BLANK, 40, blank cycles appended to each line
- V_BLANK, 5, blank lines appended to each frame
- COLOR_W, 3, colour bits per pixel

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iX  in  8  write column
- iY  in  7  write row
- iColour  in  COLOR_W  write colour
- iPlot  in  1  write strobe, one pixel per cycle high
- iClear  in  1  single-cycle request to fill framebuffer with colour 0
- oBusy  out  1  high while clearing; plot writes are ignored
- oScanX  out  8  column of the pixel on oColour
- oScanY  out  7  row of the pixel on oColour
- oColour  out  COLOR_W  scanned pixel colour, 0 outside the active region
- oValid  out  1  high in the active region
- oHSync  out  1  high during horizontal blank
- oVSync  out  1  high during vertical blank lines
- oFrameStart  out  1  one-cycle pulse with pixel (0,0)
- oErrCount  out  8  out-of-range write count; see Optional Feature

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - All outputs are 0, except oBusy = 1.
  - Scan counters hcnt = 0 and vcnt = 0.
  - Clear address = 0.
  - Reset always starts an automatic clear.
- Framebuffer:
  - Size WIDTH*HEIGHT x COLOR_W, inferred RAM, one write port, one read port.
  - Address = iY*WIDTH + iX, 15 bits.
  - Contents are not reset.
- Write path:
  - When iPlot=1, oBusy=0 and iX<WIDTH and iY<HEIGHT, iColour is written at the next clk edge.
  - An out-of-range plot is dropped.
  - No backpressure. A plot while oBusy=1 is dropped silently and is not counted as an error.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on iClear=1 or on reset.
  - CLEAR writes 0 at the clear address and increments the address each cycle.
  - CLEAR -> IDLE after address WIDTH*HEIGHT-1 is written. oBusy falls on the following cycle.
  - A clear lasts exactly WIDTH*HEIGHT cycles after reset deasserts.
  - iClear during CLEAR restarts the clear at address 0.
  - Reset mid-clear restarts the clear from 0.
- Scan counters:
  - hcnt runs 0..WIDTH+H_BLANK-1 and wraps to 0, incrementing vcnt.
  - vcnt runs 0..HEIGHT+V_BLANK-1 and wraps to 0.
  - The scan runs during clear as well; a pixel already cleared reads as 0.
- Read pipeline:
  - RAM read latency is 1 cycle.
  - All scan outputs are registered so that oScanX, oScanY, oValid, oHSync, oVSync, oFrameStart and oColour describe the same pixel.
  - Total latency is 2 cycles from the counter value to the outputs.
- Active region: oValid = (hcnt<WIDTH && vcnt<HEIGHT), delayed.
  - oScanX and oScanY equal the delayed counters when valid.
  - oScanX and oScanY hold 0 when not valid.
- Sync signals:
  - oHSync = (hcnt>=WIDTH), delayed.
  - oVSync = (vcnt>=HEIGHT), delayed.
- oFrameStart is high only when the delayed (hcnt,vcnt) = (0,0).
- Read and write to the same address in the same cycle returns the old data (read-before-write). The new value appears on the next frame.
- Frame period is (WIDTH+H_BLANK)*(HEIGHT+V_BLANK) = 200*125 = 25000 cycles at the defaults.

Optional Feature:
- Macro FRAME_SCANNER_ERRCNT_EN.
- Defined:
  - oErrCount is an 8-bit register, reset to 0.
  - It increments once per cycle with iPlot=1, oBusy=0 and (iX>=WIDTH or iY>=HEIGHT).
  - It saturates at 255.
  - iClear also zeroes it.
- Not defined: oErrCount is tied to 0 and no counter logic exists.

Test Plan:
- Reset held 3 cycles, then released -> oBusy=1 for exactly 19200 cycles, then 0; the first full frame scans all oColour=0 with oValid=1.
- After clear, plot (5,7,colour 6) -> in the next frame, the cycle with oScanX=5, oScanY=7, oValid=1 shows oColour=6; all other active pixels show 0.
- Free-run 2 frames -> oFrameStart pulses every 25000 cycles.
  - oHSync high for 40 cycles per line.
  - oVSync high for 5*200 cycles per frame.
  - oValid low whenever either sync is high.
- Plot (160,0,3) and (0,120,3), then plot (159,119,2) -> the out-of-range writes leave the framebuffer unchanged; (159,119) reads 2.
  - With FRAME_SCANNER_ERRCNT_EN, oErrCount=2.
  - Issue 300 more bad plots: oErrCount=255.
- Plot during a clear, then iClear mid-clear at address 5000 -> the plotted pixel reads 0; oBusy stays high for 19200 cycles after the second iClear.
- Write (10,10,5) in the same cycle the scan reads (10,10), old value 1 -> that frame shows 1, the next frame shows 5.
